// File: rtl/calc_alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_alu_seq_if
// Purpose  : Request/response bundle for the sequential calculator ALU.
//            The requester drives start/op/operands/acc_clr; the ALU returns
//            the result, the overflow flag and its busy/done status.
// Revision : 1.0 - initial release
// ============================================================================
interface calc_alu_seq_if #(
  parameter int WIDTH = 11
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic [WIDTH-1:0] q;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, acc_clr,
    input  q, ovf, busy, done
  );

  modport slave (
    input  start, op, a, b, acc_clr,
    output q, ovf, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/calc_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : calc_alu_seq
// Purpose  : Sequential two's-complement arithmetic unit: ADD, SUB, ACC in a
//            single execute cycle, signed MUL via a WIDTH-step shift-add
//            datapath. start/busy/done handshake, explicit signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module calc_alu_seq #(
  parameter int WIDTH = 11
) (
  input  wire logic     clk,
  input  wire logic     rst,
  calc_alu_seq_if.slave bus
);

  localparam int         CW       = $clog2(WIDTH);
  localparam int         MSB      = WIDTH - 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
  localparam logic [1:0] c_op_add = 2'b00;
  localparam logic [1:0] c_op_sub = 2'b01;
  localparam logic [1:0] c_op_mul = 2'b10;
  localparam logic [1:0] c_op_acc = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched request
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;

  // Architectural state
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic               r_ovf;

  // Multiplier working registers
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  // Handshake decode
  logic w_idle;
  logic w_accept;
  logic w_clear;

  // Single-cycle arithmetic
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_acc_sum;
  logic             w_sum_ovf;
  logic             w_diff_ovf;
  logic             w_acc_ovf;
  logic [WIDTH-1:0] w_exec_q;
  logic             w_exec_ovf;

  // Multiplier step
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_pp;
  logic [2*WIDTH-1:0] w_prod_next;
  logic               w_mul_ovf;

  assign w_idle   = (r_state == S_IDLE);
  // Clear has priority over start when both arrive in IDLE.
  assign w_clear  = w_idle && bus.acc_clr;
  assign w_accept = w_idle && bus.start && !bus.acc_clr;

  assign bus.q    = r_q;
  assign bus.ovf  = r_ovf;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);

  // ---------------------------------------------------------------------
  // Add/sub/accumulate datapath with sign-rule overflow detection
  // ---------------------------------------------------------------------
  assign w_sum      = r_a + r_b;
  assign w_diff     = r_a - r_b;
  assign w_acc_sum  = r_acc + r_a;

  assign w_sum_ovf  = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
  assign w_diff_ovf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
  assign w_acc_ovf  = (r_acc[MSB] == r_a[MSB]) && (w_acc_sum[MSB] != r_acc[MSB]);

  // Select the single-cycle result for the latched opcode
  always_comb begin
    w_exec_q   = w_sum;
    w_exec_ovf = w_sum_ovf;
    case (r_op)
      c_op_sub: begin
        w_exec_q   = w_diff;
        w_exec_ovf = w_diff_ovf;
      end
      c_op_acc: begin
        w_exec_q   = w_acc_sum;
        w_exec_ovf = w_acc_ovf;
      end
      default: begin
        w_exec_q   = w_sum;
        w_exec_ovf = w_sum_ovf;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Shift-add multiplier. The multiplicand is sign-extended to 2*WIDTH and
  // shifted left each step; the multiplier is consumed LSB first. The final
  // step handles the multiplier sign bit, whose weight is -2^(WIDTH-1), so
  // that partial product is subtracted. The 2*WIDTH accumulation holds the
  // exact product even for -2^(WIDTH-1) * -2^(WIDTH-1).
  // ---------------------------------------------------------------------
  assign w_mul_last  = (r_cnt == c_last);
  assign w_pp        = r_mplier[0] ? r_mcand : '0;
  assign w_prod_next = w_mul_last ? (r_prod - w_pp) : (r_prod + w_pp);
  // Product fits in WIDTH bits only if its top WIDTH+1 bits are all equal.
  assign w_mul_ovf   = !((&w_prod_next[2*WIDTH-1:MSB]) ||
                         (~|w_prod_next[2*WIDTH-1:MSB]));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (bus.op == c_op_mul) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC:  w_state_next = S_DONE;
      S_MUL: begin
        if (w_mul_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture opcode and operands only when a request is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= 2'b00;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= bus.op;
      r_a  <= bus.a;
      r_b  <= bus.b;
    end
  end

  // Accumulator: cleared from IDLE, updated only by an ACC execute
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_clear) begin
      r_acc <= '0;
    end else if ((r_state == S_EXEC) && (r_op == c_op_acc)) begin
      r_acc <= w_acc_sum;
    end
  end

  // Multiplier working registers: seeded on accept, stepped in MUL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{bus.a[MSB]}}, bus.a};
      r_mplier <= bus.b;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_prod   <= w_prod_next;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Result register: loaded only on the edge that enters DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_q   <= w_exec_q;
      r_ovf <= w_exec_ovf;
    end else if ((r_state == S_MUL) && w_mul_last) begin
      r_q   <= w_prod_next[WIDTH-1:0];
      r_ovf <= w_mul_ovf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_alu_seq
// Purpose  : Directed scoreboard bench for calc_alu_seq (WIDTH = 11).
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_alu_seq;

  localparam int W = 11;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  typedef struct {
    logic [W-1:0] q;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  calc_alu_seq_if #(.WIDTH(W)) bus ();

  calc_alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Monitor: every done pulse consumes one expected result
  always @(negedge clk) begin
    if (bus.done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got q=%0d ovf=%0b, required no done",
                 $signed(bus.q), bus.ovf);
      end else begin
        mon_e = sb.pop_front();
        if (bus.q !== mon_e.q || bus.ovf !== mon_e.ovf) begin
          errors++;
          $display("FAIL result: got q=%0d ovf=%0b, required q=%0d ovf=%0b",
                   $signed(bus.q), bus.ovf, $signed(mon_e.q), mon_e.ovf);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (bus.busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) check("idle_timeout", 1, 0);
  endtask

  // Issue one op, push its expected result, check latency and busy span.
  // glitch: pulse a junk start (+acc_clr) in MUL cycle 5 and in DONE.
  task automatic run(input logic [1:0] op, input int a, input int b,
                     input int eq, input logic eovf, input int lat,
                     input bit glitch);
    int n;
    int nb;
    exp_t e;
    wait_idle();
    e.q   = W'(eq);
    e.ovf = eovf;
    sb.push_back(e);
    bus.op    = op;
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n  = 0;
    nb = 0;
    forever begin
      if (bus.busy) nb++;
      if (bus.done || n >= 40) break;
      if (glitch && n == 5) begin
        bus.start = 1'b1; bus.acc_clr = 1'b1;
        bus.op = OP_ADD; bus.a = W'(100); bus.b = W'(100);
      end else begin
        bus.start = 1'b0; bus.acc_clr = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0; bus.acc_clr = 1'b0;
    check("latency", n, lat);
    check("busy_cycles", nb, lat + 1);
    if (glitch) begin
      bus.start = 1'b1;
      bus.op = OP_SUB; bus.a = W'(9); bus.b = W'(4);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("start_in_done_ignored", int'(bus.busy), 0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.acc_clr = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_q",    int'(bus.q), 0);
    check("rst_ovf",  int'(bus.ovf), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // ADD / SUB boundaries
    run(OP_ADD, 1000, 23,   1023, 1'b0, 1, 1'b0);
    run(OP_ADD, 1000, 24,  -1024, 1'b1, 1, 1'b0);
    run(OP_SUB, 5, 7,         -2, 1'b0, 1, 1'b0);
    run(OP_SUB, -1024, 1,   1023, 1'b1, 1, 1'b0);
    run(OP_SUB, 0, -1024,  -1024, 1'b1, 1, 1'b0);

    // MUL, including most-negative operands
    run(OP_MUL, -32, 32,   -1024, 1'b0, 11, 1'b0);
    run(OP_MUL, 32, 32,    -1024, 1'b1, 11, 1'b0);
    run(OP_MUL, -1024, -1, -1024, 1'b1, 11, 1'b0);
    run(OP_MUL, 0, -1024,      0, 1'b0, 11, 1'b0);
    run(OP_MUL, -1024, -1024,  0, 1'b1, 11, 1'b0);
    run(OP_MUL, -1024, 1,  -1024, 1'b0, 11, 1'b0);
    run(OP_MUL, 7, -3,       -21, 1'b0, 11, 1'b0);

    // Accumulator
    wait_idle();
    bus.acc_clr = 1'b1;
    @(posedge clk); #1;
    bus.acc_clr = 1'b0;
    run(OP_ACC, 1000, 0,    1000, 1'b0, 1, 1'b0);
    run(OP_ADD, 1, 1,          2, 1'b0, 1, 1'b0);
    run(OP_ACC, 1000, 0,     -48, 1'b1, 1, 1'b0);
    // clear and start together: clear wins, no operation starts
    wait_idle();
    bus.acc_clr = 1'b1; bus.start = 1'b1;
    bus.op = OP_ADD; bus.a = W'(7); bus.b = W'(7);
    @(posedge clk); #1;
    bus.acc_clr = 1'b0; bus.start = 1'b0;
    check("clr_start_dropped", int'(bus.busy), 0);
    repeat (3) @(posedge clk);
    run(OP_ACC, 5, 0,          5, 1'b0, 1, 1'b0);

    // Starts (and acc_clr) while busy are ignored
    run(OP_MUL, 7, -3,       -21, 1'b0, 11, 1'b1);
    run(OP_ACC, 1, 0,          6, 1'b0, 1, 1'b0);

    // Asynchronous reset in the middle of a multiply
    wait_idle();
    bus.op = OP_MUL; bus.a = W'(100); bus.b = W'(3); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_q",    int'(bus.q), 0);
    check("arst_ovf",  int'(bus.ovf), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    run(OP_ADD, 2, 3,          5, 1'b0, 1, 1'b0);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
